// File: rtl/traffic_spawn_scheduler_if.sv
// Purpose: bundle of game-control inputs and per-slot car outputs for the obstacle-car scheduler.
// Latency: none, this is a plain signal bundle.
// Backpressure: none, all outputs are levels or single-cycle pulses.
interface traffic_spawn_scheduler_if #(
    parameter int NUM_CARS = 6
);
    logic                       start;
    logic                       collision;
    logic [NUM_CARS-1:0]        car_en;
    logic [10*NUM_CARS-1:0]     car_x;
    logic [10*NUM_CARS-1:0]     car_y;
    logic [5:0]                 score;
    logic [1:0]                 level;
    logic [1:0]                 game_state;
    logic                       move_tick;

    modport master (
        input  start, collision,
        output car_en, car_x, car_y, score, level, game_state, move_tick
    );

    modport slave (
        output start, collision,
        input  car_en, car_x, car_y, score, level, game_state, move_tick
    );
endinterface

// File: rtl/traffic_spawn_scheduler.sv
// Purpose: car-slot pool controller; spawns, advances and retires obstacle cars and runs IDLE/RUN/CRASH.
// Latency: car bus and move_tick update on the same edge; level lags score by one cycle.
// Backpressure: none; start/collision are sampled every cycle, outputs are free-running.
module traffic_spawn_scheduler #(
    parameter int NUM_CARS  = 6,
    parameter int TICK_DIV  = 200000,
    parameter int STEP      = 4,
    parameter int Y_LIMIT   = 480,
    parameter int SPAWN_GAP = 100,
    parameter int LANE0_X   = 170,
    parameter int LANE1_X   = 290,
    parameter int LANE2_X   = 410
) (
    input  logic                      clk,
    input  logic                      reset,
    traffic_spawn_scheduler_if.master bus
);
    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        CRASH = 2'b10
    } state_t;

    state_t state;
    state_t state_next;
    logic   clear_all;
    logic   run_step;

    logic [CNT_W-1:0]    base_cnt;
    logic [3:0]          move_div;
    logic [7:0]          lfsr;
    logic                move_tick_r;
    logic [5:0]          score;
    logic [1:0]          level;
    logic [NUM_CARS-1:0] en;
    logic [9:0]          xs [NUM_CARS];
    logic [9:0]          ys [NUM_CARS];

    logic                base_pulse;
    logic [3:0]          div_lim;
    logic                move_now;
    logic                lfsr_fb;
    logic [1:0]          level_next;
    logic [9:0]          lane_x;

    logic [NUM_CARS-1:0] en_nx;
    logic [9:0]          x_nx [NUM_CARS];
    logic [9:0]          y_nx [NUM_CARS];
    logic [7:0]          retired;
    logic [7:0]          score_sum;
    logic [5:0]          score_nx;
    logic                gap_block;
    logic                found;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; clear_all wipes the pool, run_step lets counters and cars advance.
    always_comb begin
        state_next = state;
        clear_all  = 1'b0;
        run_step   = 1'b0;
        case (state)
            IDLE: begin
                clear_all = 1'b1;
                if (bus.start) state_next = RUN;
            end
            RUN: begin
                // A collision freezes everything on the very edge it is seen.
                if (bus.collision) state_next = CRASH;
                else               run_step   = 1'b1;
            end
            CRASH: begin
                if (bus.start) begin
                    state_next = IDLE;
                    clear_all  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                clear_all  = 1'b1;
            end
        endcase
    end

    // Tick decode, level mapping and LFSR feedback.
    always_comb begin
        base_pulse = (base_cnt == CNT_LAST);
        case (level)
            2'd0:    div_lim = 4'd8;
            2'd1:    div_lim = 4'd6;
            2'd2:    div_lim = 4'd4;
            default: div_lim = 4'd2;
        endcase
        // >= so a level-up with the divider already past the new limit fires on the next pulse.
        move_now = run_step && base_pulse && ((move_div + 4'd1) >= div_lim);
        lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        if (score <= 6'd5)       level_next = 2'd0;
        else if (score <= 6'd15) level_next = 2'd1;
        else if (score <= 6'd25) level_next = 2'd2;
        else                     level_next = 2'd3;
        case (lfsr[1:0])
            2'd0:    lane_x = 10'(LANE0_X);
            2'd2:    lane_x = 10'(LANE2_X);
            default: lane_x = 10'(LANE1_X);
        endcase
    end

    // Pool update for a move tick: advance/retire from current values, then spawn into a slot free beforehand.
    always_comb begin
        en_nx     = en;
        retired   = 8'd0;
        gap_block = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < NUM_CARS; i++) begin
            x_nx[i] = xs[i];
            y_nx[i] = ys[i];
            if (en[i] && (ys[i] < 10'(SPAWN_GAP))) gap_block = 1'b1;
            if (en[i]) begin
                if ((11'(ys[i]) + 11'(STEP)) > 11'(Y_LIMIT)) begin
                    en_nx[i] = 1'b0;
                    y_nx[i]  = 10'd0;
                    retired  = retired + 8'd1;
                end else begin
                    y_nx[i] = ys[i] + 10'(STEP);
                end
            end
        end
        // Only slots idle before this tick qualify, so a slot retiring now waits a tick.
        for (int i = 0; i < NUM_CARS; i++) begin
            if (!gap_block && !found && !en[i]) begin
                found    = 1'b1;
                en_nx[i] = 1'b1;
                y_nx[i]  = 10'd0;
                x_nx[i]  = lane_x;
            end
        end
        score_sum = {2'b00, score} + retired;
        score_nx  = (score_sum > 8'd63) ? 6'd63 : score_sum[5:0];
    end

    // Datapath registers: counters, LFSR, level, slot pool and score.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_cnt    <= '0;
            move_div    <= 4'd0;
            lfsr        <= 8'hA5;
            move_tick_r <= 1'b0;
            score       <= 6'd0;
            level       <= 2'd0;
            en          <= '0;
            for (int i = 0; i < NUM_CARS; i++) begin
                xs[i] <= 10'd0;
                ys[i] <= 10'd0;
            end
        end else begin
            lfsr        <= {lfsr[6:0], lfsr_fb};
            level       <= level_next;
            move_tick_r <= move_now;
            if (clear_all) begin
                base_cnt <= '0;
                move_div <= 4'd0;
                score    <= 6'd0;
                en       <= '0;
                for (int i = 0; i < NUM_CARS; i++) begin
                    xs[i] <= 10'd0;
                    ys[i] <= 10'd0;
                end
            end else if (run_step) begin
                base_cnt <= base_pulse ? '0 : base_cnt + CNT_W'(1);
                if (base_pulse) move_div <= move_now ? 4'd0 : move_div + 4'd1;
                if (move_now) begin
                    en    <= en_nx;
                    score <= score_nx;
                    for (int i = 0; i < NUM_CARS; i++) begin
                        xs[i] <= x_nx[i];
                        ys[i] <= y_nx[i];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CARS; g++) begin : g_pack
        assign bus.car_x[10*g +: 10] = xs[g];
        assign bus.car_y[10*g +: 10] = ys[g];
    end

    assign bus.car_en     = en;
    assign bus.score      = score;
    assign bus.level      = level;
    assign bus.game_state = state;
    assign bus.move_tick  = move_tick_r;
endmodule

// File: tb/tb_traffic_spawn_scheduler.sv
// Purpose: randomized scoreboard bench for traffic_spawn_scheduler with a behavioural game model.
// Latency: expected pool snapshots are queued at the model's move edge and popped on move_tick.
// Backpressure: none; stimulus only drives start, collision and reset.
module tb_traffic_spawn_scheduler;
    localparam int NC   = 6;
    localparam int TD   = 2;
    localparam int STEP = 4;
    localparam int YLIM = 480;
    localparam int GAP  = 100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    traffic_spawn_scheduler_if #(.NUM_CARS(NC)) bus();

    traffic_spawn_scheduler #(
        .NUM_CARS(NC), .TICK_DIV(TD), .STEP(STEP), .Y_LIMIT(YLIM), .SPAWN_GAP(GAP),
        .LANE0_X(170), .LANE1_X(290), .LANE2_X(410)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int                  cyc;
        logic [NC-1:0]       en;
        logic [10*NC-1:0]    x;
        logic [10*NC-1:0]    y;
        int                  score;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         m_en [NC];
    int         m_x  [NC];
    int         m_y  [NC];
    int         m_state, m_score, m_level, m_since;
    logic [7:0] m_lfsr;

    function automatic int level_of(input int s);
        if (s < 6)  return 0;
        if (s < 16) return 1;
        if (s < 26) return 2;
        return 3;
    endfunction

    function automatic int div_of(input int l);
        return 8 - 2 * l;
    endfunction

    function automatic int lane_of(input logic [1:0] v);
        if (v == 2'd0) return 170;
        if (v == 2'd2) return 410;
        return 290;
    endfunction

    function automatic logic [NC-1:0] pack_en();
        logic [NC-1:0] r;
        for (int i = 0; i < NC; i++) r[i] = (m_en[i] != 0);
        return r;
    endfunction

    function automatic logic [10*NC-1:0] pack_x();
        logic [10*NC-1:0] r;
        for (int i = 0; i < NC; i++) r[10*i +: 10] = 10'(m_x[i]);
        return r;
    endfunction

    function automatic logic [10*NC-1:0] pack_y();
        logic [10*NC-1:0] r;
        for (int i = 0; i < NC; i++) r[10*i +: 10] = 10'(m_y[i]);
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NC; i++) begin
            m_en[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        m_score = 0;
        m_since = 0;
    endtask

    task automatic model_move(input logic [7:0] lf);
        int   free_slot;
        int   retired;
        logic crowded;
        free_slot = -1;
        retired   = 0;
        crowded   = 1'b0;
        for (int i = 0; i < NC; i++) begin
            if (m_en[i] != 0 && m_y[i] < GAP) crowded = 1'b1;
            if (m_en[i] == 0 && free_slot < 0) free_slot = i;
        end
        for (int i = 0; i < NC; i++) begin
            if (m_en[i] != 0) begin
                if (m_y[i] + STEP > YLIM) begin
                    m_en[i] = 0; m_y[i] = 0; retired++;
                end else begin
                    m_y[i] = m_y[i] + STEP;
                end
            end
        end
        if (!crowded && free_slot >= 0) begin
            m_en[free_slot] = 1;
            m_y[free_slot]  = 0;
            m_x[free_slot]  = lane_of(lf[1:0]);
        end
        m_score = (m_score + retired > 63) ? 63 : m_score + retired;
    endtask

    // Model advances one game step per clock edge from the inputs the bench is driving.
    always @(posedge clk) begin
        logic [7:0] lf_pre;
        int         lvl_pre;
        int         sc_pre;
        exp_t       e;
        cyc++;
        if (reset) begin
            m_state = 0; m_level = 0; m_lfsr = 8'hA5;
            model_clear();
        end else begin
            lf_pre  = m_lfsr;
            lvl_pre = m_level;
            sc_pre  = m_score;
            m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            m_level = level_of(sc_pre);
            if (m_state == 0) begin
                model_clear();
                if (bus.start) m_state = 1;
            end else if (m_state == 1) begin
                if (bus.collision) begin
                    m_state = 2;
                end else begin
                    m_since++;
                    if (m_since % TD == 0 && m_since / TD >= div_of(lvl_pre)) begin
                        m_since = 0;
                        model_move(lf_pre);
                        e.cyc = cyc; e.en = pack_en(); e.x = pack_x(); e.y = pack_y(); e.score = m_score;
                        q.push_back(e);
                    end
                end
            end else begin
                if (bus.start) begin
                    m_state = 0;
                    model_clear();
                end
            end
        end
    end

    // Monitor: per-cycle state/score/level compare, full pool compare whenever move_tick is seen.
    always @(negedge clk) begin
        exp_t e;
        check("game_state", 64'(bus.game_state), 64'(m_state));
        check("score", 64'(bus.score), 64'(m_score));
        check("level", 64'(bus.level), 64'(m_level));
        check("car_en", 64'(bus.car_en), 64'(pack_en()));
        if (bus.move_tick) begin
            if (q.size() == 0) begin
                check("spurious_tick", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                check("tick_edge", 64'(cyc), 64'(e.cyc));
                check("tick_en", 64'(bus.car_en), 64'(e.en));
                check("tick_x", 64'(bus.car_x), 64'(e.x));
                check("tick_y", 64'(bus.car_y), 64'(e.y));
                check("tick_score", 64'(bus.score), 64'(e.score));
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            check("missing_tick", 64'd0, 64'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_tick(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus.move_tick) ok = 1'b1;
        end
        if (!ok) check("tick_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_score(input int target, input int budget, output logic ok);
        ok = (int'(bus.score) >= target);
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (int'(bus.score) >= target) ok = 1'b1;
        end
        if (!ok) check("score_timeout", 64'(bus.score), 64'(target));
    endtask

    function automatic logic lane_ok(input logic [9:0] x);
        return (x == 10'd170) || (x == 10'd290) || (x == 10'd410);
    endfunction

    initial begin
        logic             ok;
        int               t0;
        int               changes;
        logic [10*NC-1:0] snap_x, snap_y;
        logic [NC-1:0]    snap_en;
        logic [5:0]       snap_score;

        reset = 1'b1; bus.start = 1'b0; bus.collision = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_en", 64'(bus.car_en), 64'd0);
        check("rst_x", 64'(bus.car_x), 64'd0);
        check("rst_y", 64'(bus.car_y), 64'd0);
        check("rst_score", 64'(bus.score), 64'd0);
        check("rst_state", 64'(bus.game_state), 64'd0);
        check("rst_tick", 64'(bus.move_tick), 64'd0);
        reset = 1'b0;

        // Game 1: first spawn, gap-gated second spawn, collision on a move edge.
        repeat ($urandom_range(2, 9)) @(negedge clk);
        pulse_start();
        check("run_state", 64'(bus.game_state), 64'd1);
        t0 = cyc;
        wait_tick(64, ok);
        check("first_tick_delay", 64'(cyc - t0), 64'(8 * TD));
        check("first_en", 64'(bus.car_en), 64'd1);
        check("first_y0", 64'(bus.car_y[9:0]), 64'd0);
        check("first_x_lane", 64'(lane_ok(bus.car_x[9:0])), 64'd1);

        for (int n = 0; n < 40 && !bus.car_en[1]; n++) wait_tick(64, ok);
        check("spawn1_en", 64'(bus.car_en[1]), 64'd1);
        check("spawn1_y0", 64'(bus.car_y[9:0]), 64'd104);
        check("spawn1_y1", 64'(bus.car_y[19:10]), 64'd0);
        check("spawn1_x_lane", 64'(lane_ok(bus.car_x[19:10])), 64'd1);

        repeat ($urandom_range(1, 10)) wait_tick(64, ok);
        repeat (8 * TD - 1) @(negedge clk);
        snap_y = bus.car_y;
        bus.collision = 1'b1;
        @(negedge clk);
        bus.collision = 1'b0;
        check("crash_state", 64'(bus.game_state), 64'd2);
        check("crash_no_move", 64'(bus.car_y), 64'(snap_y));
        check("crash_no_tick", 64'(bus.move_tick), 64'd0);

        snap_x = bus.car_x; snap_y = bus.car_y; snap_en = bus.car_en; snap_score = bus.score;
        changes = 0;
        repeat (1000) begin
            @(negedge clk);
            bus.collision = 1'($urandom_range(0, 1));
            if (bus.car_x !== snap_x || bus.car_y !== snap_y || bus.car_en !== snap_en ||
                bus.score !== snap_score || bus.move_tick !== 1'b0 || bus.game_state !== 2'd2)
                changes++;
        end
        bus.collision = 1'b0;
        check("crash_hold", 64'(changes), 64'd0);

        pulse_start();
        check("idle_state", 64'(bus.game_state), 64'd0);
        check("idle_score", 64'(bus.score), 64'd0);
        check("idle_en", 64'(bus.car_en), 64'd0);
        check("idle_y", 64'(bus.car_y), 64'd0);

        // Game 2: run to retirement, level-up and score saturation.
        repeat ($urandom_range(2, 20)) @(negedge clk);
        pulse_start();
        check("run2_state", 64'(bus.game_state), 64'd1);

        wait_score(1, 5000, ok);
        check("retire_score", 64'(bus.score), 64'd1);
        check("retire_en0", 64'(bus.car_en[0]), 64'd0);
        check("retire_y0", 64'(bus.car_y[9:0]), 64'd0);

        wait_score(6, 8000, ok);
        check("lvl_lag_before", 64'(bus.level), 64'd0);
        t0 = cyc;
        @(negedge clk);
        check("lvl_lag_after", 64'(bus.level), 64'd1);
        wait_tick(64, ok);
        check("lvl1_period", 64'(cyc - t0), 64'(6 * TD));

        wait_score(63, 40000, ok);
        repeat (400) @(negedge clk);
        check("sat_score", 64'(bus.score), 64'd63);
        check("sat_level", 64'(bus.level), 64'd3);

        // Reset in the middle of a run.
        check("pre_reset_run", 64'(bus.game_state), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_state", 64'(bus.game_state), 64'd0);
        check("mid_rst_en", 64'(bus.car_en), 64'd0);
        check("mid_rst_x", 64'(bus.car_x), 64'd0);
        check("mid_rst_y", 64'(bus.car_y), 64'd0);
        check("mid_rst_score", 64'(bus.score), 64'd0);
        check("mid_rst_level", 64'(bus.level), 64'd0);
        check("mid_rst_tick", 64'(bus.move_tick), 64'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, edge %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/traffic_spawn_scheduler.md
Name: traffic_spawn_scheduler

Overview:
- Controller for the obstacle-car datapath.
- Owns a pool of NUM_CARS car slots:
  - spawns cars into free slots with lane spacing;
  - advances each active car down the screen on a level-dependent move tick;
  - retires cars at the screen bottom and accumulates score.
- Runs a game-state FSM (IDLE/RUN/CRASH).
- Its car_x/car_y/car_en buses drive the per-car sprite renderers; level drives the road animation.

Parameters:
- NUM_CARS, 6, number of car slots.
- TICK_DIV, 200000, clk cycles per base tick (500 Hz at 100 MHz).
- STEP, 4, pixels a car moves per move tick.
- Y_LIMIT, 480, retire a car when y + STEP > Y_LIMIT.
- SPAWN_GAP, 100, every active car must have y >= SPAWN_GAP before a new spawn.
- LANE0_X, 170, x of lane 0.
- LANE1_X, 290, x of lane 1.
- LANE2_X, 410, x of lane 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; IDLE->RUN or CRASH->IDLE.
- collision  in  1  level; player car overlaps an obstacle.
- car_en  out  NUM_CARS  slot active flags; bit i = slot i.
- car_x  out  10*NUM_CARS  packed slot x; slot i at bits [10i+9:10i].
- car_y  out  10*NUM_CARS  packed slot y, same packing.
- score  out  6  cars dodged, saturates at 63.
- level  out  2  0..3, derived from score.
- game_state  out  2  00 IDLE, 01 RUN, 10 CRASH.
- move_tick  out  1  one-cycle pulse when cars advance.

Behaviour:
- Reset: all outputs 0, state IDLE, base counter 0, move divider 0, LFSR = 8'hA5. Reset wins over every other input in the same cycle.
- FSM:
  - IDLE: all slots cleared (en=0, x=0, y=0), score=0, counters held at 0. start -> RUN.
  - RUN: counters run. collision=1 -> CRASH on the next edge; that edge performs no move, spawn or retire even if a move tick coincides. start ignored.
  - CRASH: counters, slots and score frozen and held on outputs. start -> IDLE; slots and score clear on entry to IDLE. collision ignored.
- Base tick (RUN only): counter 0..TICK_DIV-1. Internal base pulse for 1 cycle when count == TICK_DIV-1; counter then wraps to 0.
- Move divider (RUN only):
  - Counts base pulses.
  - move_tick is registered, high for 1 cycle after DIV[level] base pulses, where DIV = 8,6,4,2 for level 0,1,2,3.
  - Divider clears on each move_tick.
  - A level change takes effect at the next compare. If the divider already exceeds the new DIV, move_tick fires on the next base pulse.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4; shifts every clk cycle in all states except reset.
- On each move_tick, in one cycle, using pre-update values:
  - Advance: each slot with en=1 gets y <= y + STEP.
  - Retire: slots with y + STEP > Y_LIMIT get en<=0, y<=0. score += popcount(retired), saturating at 63.
  - Spawn, at most one per tick:
    - Allowed only if no slot has en=1 and y < SPAWN_GAP (evaluated before advance) and at least one slot was free before this tick.
    - Target is the lowest-index free slot: en<=1, y<=0, x<=lane X.
    - Lane = LFSR[1:0]; value 3 maps to lane 1.
    - A slot retiring on this tick is not eligible for spawn until the next tick.
- Level: registered from score with 1-cycle lag. 0-5 -> 0; 6-15 -> 1; 16-25 -> 2; >=26 -> 3.
- Timing: car_x/car_y/car_en update on the edge that asserts move_tick; renderers see new positions the same cycle move_tick is high.

Test Plan:
- Reset, then start pulse -> game_state=01. After 8*TICK_DIV cycles, first move_tick; slot0 en=1, y=0, x in {170,290,410}; other slots en=0.
- Let slot0 run to y=100 -> on the next move_tick slot1 spawns (y=0) while slot0 y=104. No spawn on any earlier tick.
- Single car reaches y=480 -> on the next move_tick that slot has en=0, y=0 and score increments by 1. Two cars retiring on the same tick -> score +2.
- Force score to 5 then retire one car -> level goes 0->1 one cycle after score=6. Move period then becomes 6*TICK_DIV.
- collision pulse in RUN on the same edge as move_tick -> state 10, no y change. All outputs hold for 1000 cycles. start -> state 00, score=0, car_en=0.
- Score at 63, retire a car -> score stays 63, level 3. reset asserted during RUN -> all outputs 0, state 00 next edge.
